// File: rtl/lsu_split_ctrl_if.sv
// Word-organised, byte-masked memory beat port used by lsu_split_ctrl.
// master: the load/store unit issuing beats; slave: the data memory.
interface lsu_split_ctrl_if #(
    parameter int ADDR_W = 16
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-3:0] addr;
    logic [3:0]        bmask;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output req, we, addr, bmask, wdata, input ack, rdata);
    modport slave  (input req, we, addr, bmask, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_split_ctrl.sv
// Load/store initiator: turns a byte-addressed RV32 load/store into one or two
// word beats on a req/ack memory port, then returns a single-cycle response.
// Loads are reassembled and sign/zero-extended.
// Optional build macro MISALIGN_TRAP_EN: word-crossing accesses are rejected
// with an error response instead of being split into two beats.
module lsu_split_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_func3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    lsu_split_ctrl_if.master  mem
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Byte enables for an access of this func3 size, right-justified.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            2'b10:   size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: is_legal = 1'b1;
            3'b100, 3'b101:         is_legal = ~we;
            default:                is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] beat0_mask(input logic [2:0] f3, input logic [1:0] off);
        beat0_mask = size_mask(f3) << off;
    endfunction

    function automatic logic [3:0] beat1_mask(input logic [2:0] f3, input logic [1:0] off);
        beat1_mask = size_mask(f3) >> (3'd4 - {1'b0, off});
    endfunction

    function automatic logic [31:0] beat0_data(input logic [31:0] wd, input logic [1:0] off);
        beat0_data = wd << {off, 3'b000};
    endfunction

    function automatic logic [31:0] beat1_data(input logic [31:0] wd, input logic [1:0] off);
        beat1_data = wd >> (6'd32 - {1'b0, off, 3'b000});
    endfunction

    // Align the two captured words down to the access offset, then extend.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] sh;
        sh = {hi, lo} >> {off, 3'b000};
        case (f3)
            3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
            3'b010:  load_extend = sh[31:0];
            3'b100:  load_extend = {24'h000000, sh[7:0]};
            3'b101:  load_extend = {16'h0000, sh[15:0]};
            default: load_extend = 32'h0000_0000;
        endcase
    endfunction

    state_t              r_state, w_state_nxt;
    logic                r_we;
    logic [2:0]          r_func3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                w_accept;
    logic [1:0]          w_off;
    logic                w_in_legal;

    logic                r_req_ready, w_req_ready_nxt;
    logic                r_mem_req, w_mem_req_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-3:0]   r_mem_addr, w_mem_addr_nxt;
    logic [3:0]          r_mem_bmask, w_mem_bmask_nxt;
    logic [31:0]         r_mem_wdata, w_mem_wdata_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0]         r_rsp_rdata, w_rsp_rdata_nxt;
    logic                r_rsp_err, w_rsp_err_nxt;

    assign w_off      = r_addr[1:0];
    assign w_in_legal = is_legal(i_req_we, i_req_func3);

`ifdef MISALIGN_TRAP_EN
    logic w_in_split;
    assign w_in_split = |beat1_mask(i_req_func3, i_req_addr[1:0]);
`else
    logic        w_split;
    logic [31:0] r_lo, w_lo_nxt;
    assign w_split = |beat1_mask(r_func3, w_off);
`endif

    // Next state and next registered outputs; every output defaults to idle-low.
    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_req_ready_nxt = 1'b0;
        w_mem_req_nxt   = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = {(ADDR_W-2){1'b0}};
        w_mem_bmask_nxt = 4'b0000;
        w_mem_wdata_nxt = 32'h0000_0000;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = 32'h0000_0000;
        w_rsp_err_nxt   = 1'b0;
`ifndef MISALIGN_TRAP_EN
        w_lo_nxt        = r_lo;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_accept = 1'b1;
`ifdef MISALIGN_TRAP_EN
                    if (!w_in_legal || w_in_split) begin
`else
                    if (!w_in_legal) begin
`endif
                        w_state_nxt     = ST_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt     = ST_BEAT0;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = i_req_we;
                        w_mem_addr_nxt  = i_req_addr[ADDR_W-1:2];
                        w_mem_bmask_nxt = beat0_mask(i_req_func3, i_req_addr[1:0]);
                        w_mem_wdata_nxt = beat0_data(i_req_wdata, i_req_addr[1:0]);
                    end
                end else begin
                    w_req_ready_nxt = 1'b1;
                end
            end
            ST_BEAT0: begin
                if (mem.ack) begin
`ifndef MISALIGN_TRAP_EN
                    w_lo_nxt = mem.rdata;
                    if (w_split) begin
                        w_state_nxt     = ST_BEAT1;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = r_we;
                        w_mem_addr_nxt  = r_addr[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};
                        w_mem_bmask_nxt = beat1_mask(r_func3, w_off);
                        w_mem_wdata_nxt = beat1_data(r_wdata, w_off);
                    end else begin
                        w_state_nxt     = ST_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = r_we ? 32'h0000_0000
                                               : load_extend(r_func3, w_off, 32'h0000_0000, mem.rdata);
                    end
`else
                    w_state_nxt     = ST_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_we ? 32'h0000_0000
                                           : load_extend(r_func3, w_off, 32'h0000_0000, mem.rdata);
`endif
                end else begin
                    w_mem_req_nxt   = r_mem_req;
                    w_mem_we_nxt    = r_mem_we;
                    w_mem_addr_nxt  = r_mem_addr;
                    w_mem_bmask_nxt = r_mem_bmask;
                    w_mem_wdata_nxt = r_mem_wdata;
                end
            end
`ifndef MISALIGN_TRAP_EN
            ST_BEAT1: begin
                if (mem.ack) begin
                    w_state_nxt     = ST_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_we ? 32'h0000_0000
                                           : load_extend(r_func3, w_off, mem.rdata, r_lo);
                end else begin
                    w_mem_req_nxt   = r_mem_req;
                    w_mem_we_nxt    = r_mem_we;
                    w_mem_addr_nxt  = r_mem_addr;
                    w_mem_bmask_nxt = r_mem_bmask;
                    w_mem_wdata_nxt = r_mem_wdata;
                end
            end
`endif
            ST_RESP: begin
                w_state_nxt     = ST_IDLE;
                w_req_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_req_ready_nxt = 1'b1;
            end
        endcase
    end

    // State register and registered outputs; reset abandons any beat in flight.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {(ADDR_W-2){1'b0}};
            r_mem_bmask <= 4'b0000;
            r_mem_wdata <= 32'h0000_0000;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_bmask <= w_mem_bmask_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    // Request fields are captured once at acceptance and held for the whole access.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_we    <= 1'b0;
            r_func3 <= 3'b000;
            r_addr  <= {ADDR_W{1'b0}};
            r_wdata <= 32'h0000_0000;
        end else if (w_accept) begin
            r_we    <= i_req_we;
            r_func3 <= i_req_func3;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
        end else begin
            r_we    <= r_we;
            r_func3 <= r_func3;
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
        end
    end

`ifndef MISALIGN_TRAP_EN
    // Low word of a split load, kept until the second beat completes.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_lo <= 32'h0000_0000;
        end else begin
            r_lo <= w_lo_nxt;
        end
    end
`endif

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign mem.req     = r_mem_req;
    assign mem.we      = r_mem_we;
    assign mem.addr    = r_mem_addr;
    assign mem.bmask   = r_mem_bmask;
    assign mem.wdata   = r_mem_wdata;

endmodule

// File: tb/tb_lsu_split_ctrl.sv
// Self-checking bench for lsu_split_ctrl: a memory responder with programmable
// ack delay, and a byte-level reference model of memory and load extension.
module tb_lsu_split_ctrl;

    typedef struct packed {
        logic        we;
        logic [13:0] waddr;
        logic [3:0]  bmask;
        logic [31:0] wdata;
    } beat_t;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_func3;
    logic [15:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    lsu_split_ctrl_if #(.ADDR_W(16)) mem_if ();

    lsu_split_ctrl #(.ADDR_W(16)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_func3 (i_req_func3),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .mem         (mem_if)
    );

    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    bit   [31:0] pmem [0:16383];
    bit   [7:0]  rmem [0:65535];
    beat_t       beat_log [$];
    int          last_base;
    int          ack_delay = 0;
    bit          ack_block = 1'b0;
    bit          ack_noise = 1'b1;
    int          wait_cnt = 0;
    bit          pre_en = 1'b0;
    logic [13:0] pre_idx;
    logic [31:0] pre_val;

    // Memory responder: ack after ack_delay waiting cycles; stray acks while idle.
    always @(negedge i_clk) begin
        if (mem_if.req) begin
            mem_if.ack   <= (wait_cnt >= ack_delay) && !ack_block;
            mem_if.rdata <= pmem[mem_if.addr];
        end else begin
            mem_if.ack   <= ack_noise && ($urandom_range(0, 1) == 1);
            mem_if.rdata <= $urandom;
        end
    end

    // Completed beats are logged and applied to the physical memory.
    always @(posedge i_clk) begin
        if (pre_en) pmem[pre_idx] <= pre_val;
        if (mem_if.req && mem_if.ack) begin
            beat_log.push_back(beat_t'({mem_if.we, mem_if.addr, mem_if.bmask, mem_if.wdata}));
            if (mem_if.we) begin
                for (int k = 0; k < 4; k++)
                    if (mem_if.bmask[k]) pmem[mem_if.addr][8*k +: 8] <= mem_if.wdata[8*k +: 8];
            end
            wait_cnt <= 0;
        end else if (mem_if.req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic preload(input logic [13:0] idx, input logic [31:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_en  = 1'b1;
        for (int k = 0; k < 4; k++) rmem[{idx, 2'(k)}] = val[8*k +: 8];
        @(posedge i_clk); #1;
        pre_en = 1'b0;
    endtask

    // One request end to end, checked against the byte-level reference model.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                          input logic [31:0] wd, input int d,
                          output logic [31:0] got_rd, output logic got_err);
        beat_t       eb [2];
        beat_t       act;
        int          nb, size, exp_lat, lat, base;
        bit          legal, seen;
        logic [15:0] b;
        logic [31:0] val, exp_rd, m;
        logic        exp_err;
        legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        exp_err = !legal;
`ifdef MISALIGN_TRAP_EN
        if (int'(addr[1:0]) + size > 4) exp_err = 1'b1;
`endif
        nb = 0; val = 32'h0; exp_rd = 32'h0;
        if (!exp_err) begin
            for (int i = 0; i < size; i++) begin
                b = addr + 16'(i);
                if (nb == 0 || eb[nb-1].waddr != b[15:2]) begin
                    eb[nb] = {we, b[15:2], 4'b0000, 32'h0};
                    nb++;
                end
                eb[nb-1].bmask[b[1:0]] = 1'b1;
                if (we) begin
                    eb[nb-1].wdata[8*b[1:0] +: 8] = wd[8*i +: 8];
                    rmem[b] = wd[8*i +: 8];
                end else begin
                    val[8*i +: 8] = rmem[b];
                end
            end
            if (!we) begin
                case (f3)
                    3'd0:    exp_rd = {{24{val[7]}}, val[7:0]};
                    3'd1:    exp_rd = {{16{val[15]}}, val[15:0]};
                    3'd4:    exp_rd = {24'h0, val[7:0]};
                    3'd5:    exp_rd = {16'h0, val[15:0]};
                    default: exp_rd = val;
                endcase
            end
        end
        exp_lat = exp_err ? 1 : 1 + nb * (1 + d);
        ack_delay = d;
        base = beat_log.size();
        last_base = base;
        n_checks++;
        if (o_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL ready_before_req: got %b expected 1", o_req_ready);
        end
        i_req_valid = 1'b1; i_req_we = we; i_req_func3 = f3; i_req_addr = addr; i_req_wdata = wd;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0; i_req_we = 1'($urandom); i_req_func3 = 3'($urandom);
        i_req_addr = 16'($urandom); i_req_wdata = $urandom;
        lat = 1; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge i_clk);
            if (o_rsp_valid) seen = 1'b1;
            else begin @(posedge i_clk); #1; lat++; end
        end
        n_checks++;
        if (!seen || lat != exp_lat) begin
            n_errors++; $display("FAIL latency: got %0d (seen=%0d) expected %0d", lat, seen, exp_lat);
        end
        n_checks++;
        if ({o_req_ready, o_rsp_err, o_rsp_rdata} !== {1'b0, exp_err, exp_rd}) begin
            n_errors++;
            $display("FAIL response: addr=%h f3=%0d we=%0d got ready=%b err=%b rdata=%h expected ready=0 err=%b rdata=%h",
                     addr, f3, we, o_req_ready, o_rsp_err, o_rsp_rdata, exp_err, exp_rd);
        end
        got_rd = o_rsp_rdata; got_err = o_rsp_err;
        n_checks++;
        if (beat_log.size() - base != nb) begin
            n_errors++; $display("FAIL beat_count: addr=%h got %0d expected %0d", addr, beat_log.size() - base, nb);
        end else begin
            for (int j = 0; j < nb; j++) begin
                act = beat_log[base + j];
                m = {{8{act.bmask[3]}}, {8{act.bmask[2]}}, {8{act.bmask[1]}}, {8{act.bmask[0]}}};
                n_checks++;
                if ({act.we, act.waddr, act.bmask, we ? (act.wdata & m) : 32'h0} !==
                    {eb[j].we, eb[j].waddr, eb[j].bmask, we ? eb[j].wdata : 32'h0}) begin
                    n_errors++;
                    $display("FAIL beat%0d: got we=%b addr=%h bmask=%b wdata=%h expected we=%b addr=%h bmask=%b wdata=%h",
                             j, act.we, act.waddr, act.bmask, act.wdata, eb[j].we, eb[j].waddr, eb[j].bmask, eb[j].wdata);
                end
            end
        end
        @(posedge i_clk); #1;
        @(negedge i_clk);
        n_checks++;
        if ({o_rsp_valid, o_req_ready} !== 2'b01) begin
            n_errors++; $display("FAIL after_resp: got valid=%b ready=%b expected valid=0 ready=1", o_rsp_valid, o_req_ready);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        #2 i_reset = 1'b0;
        #4;
        n_checks++;
        if ({o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata, mem_if.req, mem_if.we,
             mem_if.addr, mem_if.bmask, mem_if.wdata} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0}) begin
            n_errors++; $display("FAIL reset_outputs: got ready=%b valid=%b req=%b expected ready=1 all others 0",
                                 o_req_ready, o_rsp_valid, mem_if.req);
        end
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_store_word();
        logic [31:0] rd; logic er;
        run_op(1'b1, 3'b010, 16'h0010, 32'hDEADBEEF, 0, rd, er);
        n_checks++;
        if (beat_log.size() != last_base + 1 || beat_log[last_base] !== {1'b1, 14'h0004, 4'b1111, 32'hDEADBEEF}
            || rd !== 32'h0 || er !== 1'b0) begin
            n_errors++; $display("FAIL sw_beat: got rd=%h err=%b beats=%0d expected one beat addr 004 bmask 1111 DEADBEEF",
                                 rd, er, beat_log.size() - last_base);
        end
    endtask

    task automatic test_split_load();
        logic [31:0] rd; logic er;
        preload(14'h0004, 32'h44332211);
        preload(14'h0005, 32'h88776655);
        run_op(1'b0, 3'b010, 16'h0013, $urandom, 0, rd, er);
        n_checks++;
`ifndef MISALIGN_TRAP_EN
        if (rd !== 32'h77665544 || beat_log.size() != last_base + 2 ||
            beat_log[last_base].bmask !== 4'b1000 || beat_log[last_base + 1].waddr !== 14'h0005 ||
            beat_log[last_base + 1].bmask !== 4'b0111) begin
            n_errors++; $display("FAIL lw_split: got rdata=%h expected 77665544 with beats 4/1000 then 5/0111", rd);
        end
`else
        if (er !== 1'b1 || rd !== 32'h0 || beat_log.size() != last_base) begin
            n_errors++; $display("FAIL lw_trap: got err=%b rdata=%h expected err=1 rdata=0 and no beat", er, rd);
        end
`endif
    endtask

    task automatic test_split_half();
        logic [31:0] rd; logic er;
        run_op(1'b1, 3'b001, 16'h0003, 32'h0000ABCD, 0, rd, er);
`ifndef MISALIGN_TRAP_EN
        n_checks++;
        if (beat_log.size() != last_base + 2 || beat_log[last_base] !== {1'b1, 14'h0000, 4'b1000, 32'hCD000000}
            || beat_log[last_base + 1] !== {1'b1, 14'h0001, 4'b0001, 32'h000000AB}) begin
            n_errors++; $display("FAIL sh_split: beats differ from 0/1000/CD000000 and 1/0001/000000AB");
        end
`endif
        preload(14'h0000, 32'h34112233);
        preload(14'h0001, 32'h55667792);
        run_op(1'b0, 3'b001, 16'h0003, $urandom, 1, rd, er);
`ifndef MISALIGN_TRAP_EN
        n_checks++;
        if (rd !== 32'hFFFF9234) begin
            n_errors++; $display("FAIL lh_split: got %h expected FFFF9234", rd);
        end
`endif
        run_op(1'b0, 3'b101, 16'h0003, $urandom, 0, rd, er);
`ifndef MISALIGN_TRAP_EN
        n_checks++;
        if (rd !== 32'h00009234) begin
            n_errors++; $display("FAIL lhu_split: got %h expected 00009234", rd);
        end
`endif
    endtask

    task automatic test_hold_stable();
        logic [31:0] rd; logic er;
        int k;
        preload(14'h0001, 32'h00800000);
        ack_delay = 3;
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_func3 = 3'b000; i_req_addr = 16'h0006; i_req_wdata = $urandom;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0; i_req_addr = 16'($urandom);
        for (k = 0; k < 4; k++) begin
            @(negedge i_clk);
            n_checks++;
            if ({mem_if.req, mem_if.we, mem_if.addr, mem_if.bmask} !== {1'b1, 1'b0, 14'h0001, 4'b0100}) begin
                n_errors++; $display("FAIL hold_cycle%0d: got req=%b addr=%h bmask=%b expected 1/0001/0100",
                                     k, mem_if.req, mem_if.addr, mem_if.bmask);
            end
            @(posedge i_clk); #1;
        end
        @(negedge i_clk);
        n_checks++;
        if ({o_rsp_valid, o_rsp_err, o_rsp_rdata} !== {1'b1, 1'b0, 32'hFFFFFF80}) begin
            n_errors++; $display("FAIL lb_delayed: got valid=%b rdata=%h expected valid=1 rdata=FFFFFF80", o_rsp_valid, o_rsp_rdata);
        end
        @(posedge i_clk); #1;
        run_op(1'b0, 3'b100, 16'h0006, $urandom, 3, rd, er);
        n_checks++;
        if (rd !== 32'h00000080) begin
            n_errors++; $display("FAIL lbu_delayed: got %h expected 00000080", rd);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic er;
        run_op(1'b0, 3'b011, 16'h0020, $urandom, 0, rd, er);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0 || beat_log.size() != last_base) begin
            n_errors++; $display("FAIL illegal_load: got err=%b rdata=%h expected err=1 rdata=0 and no beat", er, rd);
        end
        run_op(1'b1, 3'b100, 16'h0024, $urandom, 0, rd, er);
        n_checks++;
        if (er !== 1'b1 || beat_log.size() != last_base) begin
            n_errors++; $display("FAIL illegal_store: got err=%b expected 1 and no beat", er);
        end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] rd; logic er;
        int rsp_seen;
        preload(14'h3FFF, 32'hA1B2C3D4);
        preload(14'h0000, 32'h5566E7F8);
        run_op(1'b0, 3'b010, 16'hFFFE, $urandom, 0, rd, er);
`ifndef MISALIGN_TRAP_EN
        n_checks++;
        if (rd !== 32'hE7F8A1B2 || beat_log.size() != last_base + 2 || beat_log[last_base + 1].waddr !== 14'h0000) begin
            n_errors++; $display("FAIL lw_wrap: got rdata=%h expected E7F8A1B2 with second beat at word 0", rd);
        end
`endif
        ack_delay = 0;
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_func3 = 3'b010;
`ifndef MISALIGN_TRAP_EN
        i_req_addr = 16'hFFFE;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        @(posedge i_clk); #1;
        ack_block = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if ({mem_if.req, mem_if.addr, mem_if.bmask} !== {1'b1, 14'h0000, 4'b0011}) begin
            n_errors++; $display("FAIL beat1_wrap: got req=%b addr=%h bmask=%b expected 1/0000/0011",
                                 mem_if.req, mem_if.addr, mem_if.bmask);
        end
`else
        i_req_addr = 16'hFFFC;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        ack_block = 1'b1;
`endif
        @(posedge i_clk); #1;
        #2 i_reset = 1'b0;
        #1;
        n_checks++;
        if ({o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata, mem_if.req, mem_if.we,
             mem_if.addr, mem_if.bmask, mem_if.wdata} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0}) begin
            n_errors++; $display("FAIL mid_reset: got ready=%b req=%b addr=%h expected ready=1 all others 0",
                                 o_req_ready, mem_if.req, mem_if.addr);
        end
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        ack_block = 1'b0;
        rsp_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (o_rsp_valid || mem_if.req) rsp_seen++;
            @(posedge i_clk); #1;
        end
        n_checks++;
        if (rsp_seen != 0 || o_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL post_reset_quiet: got %0d active cycles ready=%b expected 0 and ready=1",
                                 rsp_seen, o_req_ready);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er;
        for (int w = 16'h40; w <= 16'h50; w++) preload(14'(w), $urandom);
        for (int n = 0; n < 40; n++) begin
            ack_noise = 1'($urandom);
            run_op(1'($urandom), 3'($urandom), 16'h0100 + 16'($urandom_range(0, 63)), $urandom,
                   $urandom_range(0, 2), rd, er);
        end
        ack_noise = 1'b1;
    endtask

    initial begin
        i_reset = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_func3 = 3'b000;
        i_req_addr = 16'h0; i_req_wdata = 32'h0;
        test_reset();
        test_store_word();
        test_split_load();
        test_split_half();
        test_hold_stable();
        test_illegal();
        test_wrap_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_split_ctrl.md
Name: lsu_split_ctrl

Overview:
Load/store initiator between the core datapath and a word-organised, byte-masked data memory port.
Accepts one load/store request at a time and converts the byte address and func3 into word-address and byte-mask beats on a req/ack memory port.
Accesses that cross a word boundary are split into two sequential beats.
Load data is reassembled and sign/zero-extended, then returned as a single-cycle response.

Parameters:
ADDR_W, 16, byte-address width; memory word address is ADDR_W-2 bits.

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous active-low reset
i_req_valid  input  1  core request valid
o_req_ready  output  1  block can accept a request (IDLE only)
i_req_we  input  1  1=store, 0=load
i_req_func3  input  3  RV32 load/store func3
i_req_addr  input  ADDR_W  byte address
i_req_wdata  input  32  store data, right-justified
o_rsp_valid  output  1  one-cycle response strobe
o_rsp_rdata  output  32  extended load data; 0 for stores/errors
o_rsp_err  output  1  illegal func3, valid with o_rsp_valid
o_mem_req  output  1  memory beat request
o_mem_we  output  1  beat is a write
o_mem_addr  output  ADDR_W-2  word address
o_mem_bmask  output  4  byte enables, bit n = byte lane n
o_mem_wdata  output  32  lane-aligned write data
i_mem_ack  input  1  beat accepted/completed; may assert in the same cycle as o_mem_req
i_mem_rdata  input  32  read word, valid when i_mem_ack=1

Behaviour:
- Reset: async on i_reset=0. State goes to IDLE; every output is 0 except o_req_ready=1. Reset mid-operation abandons the beat in progress, and no response is issued.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: o_req_ready=1. On i_req_valid=1, latch we, func3, addr and wdata.
  - Legal func3: loads 000/001/010/100/101; stores 000/001/010.
  - Legal request -> BEAT0. Illegal request -> RESP with err=1 and no memory beat.
- Size: byte=1, half=2, word=4. off=addr[1:0].
- split = (off+size > 4), i.e. half at off 3, or word at off 1/2/3.
- BEAT0:
  - o_mem_req=1, o_mem_addr=addr[ADDR_W-1:2].
  - o_mem_bmask=(sizemask<<off)[3:0], where sizemask is 0001/0011/1111.
  - o_mem_wdata=wdata<<(8*off).
  - All mem outputs are held stable until i_mem_ack.
  - On ack, capture i_mem_rdata into lo. Then go to BEAT1 if split, else RESP.
- BEAT1:
  - o_mem_addr=word address+1, modulo 2^(ADDR_W-2) (wraps to 0).
  - o_mem_bmask=sizemask>>(4-off).
  - o_mem_wdata=wdata>>(8*(4-off)).
  - On ack, capture hi and go to RESP.
- i_mem_ack is ignored outside BEAT0/BEAT1.
- RESP: o_rsp_valid=1 for exactly one cycle, then IDLE. There is no response back-pressure.
  - Loads: o_rsp_rdata=({hi,lo}>>(8*off)) truncated to size; sign-extended for 000/001, zero-extended for 100/101.
  - hi is 0 when the access is not split.
- Latency with same-cycle ack:
  - Unsplit: accept at cycle 0, beat at 1, rsp at 2.
  - Split: rsp at 3.
- o_mem_req=0 in IDLE and RESP. o_mem_we equals the latched we during beats, 0 otherwise.
- Throughput: a new request is accepted only in IDLE, one cycle after the RESP strobe.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: a split access is not issued. The block goes IDLE->RESP with o_rsp_err=1, o_rsp_rdata=0 and no mem beat; BEAT1 logic is removed.
- Undefined: split accesses are executed as two beats as described above.

Test Plan:
- SW addr 0x0010 wdata 0xDEADBEEF, ack same cycle -> one beat: addr 0x004, bmask 1111, wdata 0xDEADBEEF, we=1; rsp_valid at cycle 2, rdata 0, err 0.
- LW addr 0x0013, word4=0x44332211, word5=0x88776655 -> beats at addr 4 bmask 1000, then addr 5 bmask 0111; rdata 0x77665544.
- SH addr 0x0003 wdata 0x0000ABCD -> beat0 addr 0 bmask 1000 wdata 0xCD000000; beat1 addr 1 bmask 0001 wdata 0x000000AB. LH at the same address with word0=0x34xxxxxx, word1=0xxxxxxx92 -> 0xFFFF9234; LHU -> 0x00009234.
- LB addr 0x0006, word1=0x00800000, ack delayed 3 cycles -> mem outputs held stable for 3 cycles, rdata 0xFFFFFF80. LBU -> 0x00000080.
- func3=011 load -> no o_mem_req. Rsp at cycle 1 with err=1, rdata 0. With MISALIGN_TRAP_EN, LW 0x0013 -> err=1 and no beat.
- LW addr 0xFFFE -> beat1 o_mem_addr wraps to 0x0000. Assert i_reset=0 while waiting for ack in BEAT1 -> immediate IDLE, outputs 0, ready=1, and no rsp_valid after release.
